// File: rtl/i2c_pkg.sv
// Shared widths and FSM encoding used by the requester arbiter and the I2C controller.
package i2c_pkg;
   localparam int ADDR_W = 7;
   localparam int REG_W  = 8;
   localparam int DATA_W = 16;
   localparam int TCNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_ACTIVE,
      ST_COMPLETE,
      ST_DRAIN
   } state_t;
endpackage

// File: rtl/i2c_arbiter_if.sv
// Arbiter-to-controller command bus.
interface i2c_arbiter_if;
   import i2c_pkg::*;

   // ctl_en is a level request: the controller raises ctl_busy once it starts,
   // drops it when finished, and the fields stay stable while ctl_en is high.
   logic              ctl_en;
   logic [ADDR_W-1:0] ctl_addr;
   logic [REG_W-1:0]  ctl_reg;
   logic              ctl_rw;
   logic [DATA_W-1:0] ctl_din;
   logic              ctl_busy;
   logic [DATA_W-1:0] ctl_dout;

   modport master (
      output ctl_en, ctl_addr, ctl_reg, ctl_rw, ctl_din,
      input  ctl_busy, ctl_dout
   );
   modport slave (
      input  ctl_en, ctl_addr, ctl_reg, ctl_rw, ctl_din,
      output ctl_busy, ctl_dout
   );
endinterface

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module i2c_rr_arbiter #(
   parameter int  N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);
   int               cand;
   logic [N_REQ-1:0] rot;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      rot   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(ptr) + k) % N_REQ;
         rot  = req >> cand;
         if (!valid && rot[0]) begin
            valid = 1'b1;
            idx   = IDX_W'(cand);
            gnt   = N_REQ'(1) << cand;
         end
      end
   end
endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C controller between N_REQ requesters with round-robin grants,
// a per-busy-edge timeout and a drain phase so the controller cannot restart early.
module i2c_arbiter
   import i2c_pkg::*;
#(
   parameter int  N_REQ       = 4,
   parameter int  TIMEOUT_CYC = 65535,
   localparam int IDX_W       = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [ADDR_W*N_REQ-1:0] req_addr,
   input  logic [REG_W*N_REQ-1:0]  req_reg,
   input  logic [N_REQ-1:0]        req_rw,
   input  logic [DATA_W*N_REQ-1:0] req_din,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        done,
   output logic [DATA_W-1:0]       rsp_dout,
   output logic                    rsp_err,
   output state_t                  state_dbg,
   i2c_arbiter_if.master           ctl
);
   state_t            state_q, state_n;
   logic [IDX_W-1:0]  ptr_q, g_idx_q;
   logic              busy_s1_q, busy_s2_q;
   logic [TCNT_W-1:0] tcnt_q;
   logic              timeout;
   logic              err_q;
   logic              drain_low_q;
   logic [N_REQ-1:0]  arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_valid;

   i2c_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req   (req),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign timeout   = (tcnt_q == TCNT_W'(TIMEOUT_CYC));
   assign state_dbg = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_n;
   end

   // DRAIN guarantees the synchronized busy is low on entry to LAUNCH,
   // so a high level there is the rising edge.
   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE:     if (arb_valid) state_n = ST_LAUNCH;
         ST_LAUNCH:   if (timeout || busy_s2_q) state_n = timeout ? ST_COMPLETE : ST_ACTIVE;
         ST_ACTIVE:   if (timeout || !busy_s2_q) state_n = ST_COMPLETE;
         ST_COMPLETE: state_n = ST_DRAIN;
         ST_DRAIN:    if (!busy_s2_q && drain_low_q) state_n = ST_IDLE;
         default:     state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q        <= '0;
         g_idx_q      <= '0;
         busy_s1_q    <= 1'b0;
         busy_s2_q    <= 1'b0;
         tcnt_q       <= '0;
         err_q        <= 1'b0;
         drain_low_q  <= 1'b0;
         gnt          <= '0;
         done         <= '0;
         rsp_dout     <= '0;
         rsp_err      <= 1'b0;
         ctl.ctl_en   <= 1'b0;
         ctl.ctl_addr <= '0;
         ctl.ctl_reg  <= '0;
         ctl.ctl_rw   <= 1'b0;
         ctl.ctl_din  <= '0;
      end else begin
         busy_s1_q <= ctl.ctl_busy;
         busy_s2_q <= busy_s1_q;
         done      <= '0;
         if (state_n != state_q)
            tcnt_q <= '0;
         else if (state_q == ST_LAUNCH || state_q == ST_ACTIVE)
            tcnt_q <= tcnt_q + 1'b1;

         case (state_q)
            ST_IDLE: if (arb_valid) begin
               gnt          <= arb_gnt;
               g_idx_q      <= arb_idx;
               err_q        <= 1'b0;
               ctl.ctl_en   <= 1'b1;
               ctl.ctl_addr <= req_addr[arb_idx*ADDR_W +: ADDR_W];
               ctl.ctl_reg  <= req_reg[arb_idx*REG_W +: REG_W];
               ctl.ctl_rw   <= req_rw[arb_idx];
               ctl.ctl_din  <= req_din[arb_idx*DATA_W +: DATA_W];
            end
            ST_LAUNCH, ST_ACTIVE: if (state_n == ST_COMPLETE) begin
               ctl.ctl_en <= 1'b0;
               err_q      <= timeout;
            end
            ST_COMPLETE: begin
               done        <= gnt;
               gnt         <= '0;
               rsp_err     <= err_q;
               rsp_dout    <= err_q ? '0 : ctl.ctl_dout;
               ptr_q       <= (g_idx_q == IDX_W'(N_REQ - 1)) ? '0 : g_idx_q + 1'b1;
               drain_low_q <= 1'b0;
            end
            ST_DRAIN: drain_low_q <= !busy_s2_q;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 65535: number of clk cycles allowed for each ctl_busy edge.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1: system clock, the only clock.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port req, input, N_REQ: per-requester transaction request, level.
REQ-007 Port req_addr, input, 7*N_REQ: packed 7-bit peripheral addresses, requester i at [7i+6:7i].
REQ-008 Port req_reg, input, 8*N_REQ: packed target register bytes.
REQ-009 Port req_rw, input, N_REQ: per-requester rw bit, passed unchanged to the controller.
REQ-010 Port req_din, input, 16*N_REQ: packed write data words.
REQ-011 Port gnt, output, N_REQ: one-hot grant, high from launch until done.
REQ-012 Port done, output, N_REQ: one-cycle completion pulse to the granted requester.
REQ-013 Port rsp_dout, output, 16: read data, valid while done is high.
REQ-014 Port rsp_err, output, 1: timeout flag, valid while done is high.
REQ-015 Controller-side ports: ctl_en (out, 1), ctl_addr (out, 7), ctl_reg (out, 8), ctl_rw (out, 1), ctl_din (out, 16), ctl_busy (in, 1), ctl_dout (in, 16).

Function
REQ-016 FSM states: IDLE, LAUNCH, ACTIVE, COMPLETE, DRAIN.
REQ-017 IDLE: if any req bit is high, round-robin select starting at index ptr; latch that requester's fields into ctl_*; set gnt; go to LAUNCH.
REQ-018 LAUNCH: hold ctl_en=1; on a synchronized ctl_busy rise, go to ACTIVE.
REQ-019 ACTIVE: on a synchronized ctl_busy fall, drop ctl_en and go to COMPLETE in that same cycle.
REQ-020 COMPLETE: capture ctl_dout into rsp_dout; pulse done[g] for one cycle; clear gnt; set ptr=(g+1) mod N_REQ; go to DRAIN.
REQ-021 DRAIN: stay until the synchronized ctl_busy has been low for 2 consecutive cycles, then go to IDLE, so the controller cannot restart.
REQ-022 ctl_busy is passed through a 2-flop synchronizer before any use; arbitration latency from req to gnt is 1 clk.
REQ-023 Per-edge timeout counter: cleared on entry to LAUNCH and to ACTIVE; if it reaches TIMEOUT_CYC, drop ctl_en, set rsp_err=1 and rsp_dout=16'h0000, and go to COMPLETE.
REQ-024 ctl_* fields are constant from grant until COMPLETE; requester input changes during this time are ignored.
REQ-025 If the granted requester drops req mid-transaction, the transaction still completes and done is still pulsed.
REQ-026 A requester that holds req after done is re-arbitrated with lowest priority (ptr has moved past it).
REQ-027 At most one gnt bit and at most one done bit are high at any time.
REQ-028 Outside the granted window, ctl_en=0 and ctl_* hold their last values.

Reset
REQ-029 On rst: state=IDLE, ptr=0, ctl_en=0, ctl_addr/ctl_reg/ctl_din=0, ctl_rw=0, gnt=0, done=0, rsp_dout=0, rsp_err=0, timeout counter=0, synchronizer flops=0.
REQ-030 Reset mid-transaction aborts immediately; no done pulse is produced; the controller's own en-gating returns its bus lines to high-Z.

Structure
REQ-031 Shared package i2c_pkg holds the FSM state encoding, the field widths (7/8/16) and the timeout counter width; i2c_controller uses the same width constants.
REQ-032 One sub-module, i2c_rr_arbiter: combinational round-robin pick from req and ptr, producing a one-hot grant and its encoded index.

Verification
REQ-033 Single request: req=4'b0001, addr=7'h50, reg=8'h10, rw=1, din=16'hA55A -> ctl_* carry these values; exactly one done[0] pulse; gnt[0] is high throughout; rsp_err=0.
REQ-034 Contention: req=4'b1111 held -> grant order 0,1,2,3,0; no overlap of gnt bits.
REQ-035 Read return: controller model returns dout=16'hBEEF on the busy fall -> rsp_dout=16'hBEEF in the done[2] cycle.
REQ-036 Timeout: ctl_busy stuck at 0 after grant -> done pulses TIMEOUT_CYC+1 (+/-2) cycles later with rsp_err=1, rsp_dout=0, and ctl_en=0.
REQ-037 Input changes: req_din[1] changed and req[1] dropped mid-ACTIVE -> ctl_din is unchanged and done[1] still pulses.
REQ-038 Reset mid-ACTIVE: rst asserted -> all outputs return to reset values asynchronously; no done pulse; next request is granted from ptr=0.
